// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU_Sel encodings, ALU width and arbiter state encodings
package alu_pkg;
  localparam int ALU_W = 32;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_SLT = 4'b1000
  } alu_sel_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu: combinational ALU datapath (alu_sel, a, b -> y); unknown selects yield 0
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = '0;
    case (alu_sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SRA: y = $signed(a) >>> b[4:0];
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NUM_REQ requesters
//   ports: clk, rst (sync, active-high); req_valid/req_ready/req_sel/req_op0/req_op1 per requester;
//   resp_valid/resp_ready per requester; resp_result, resp_err shared.
//   ALU_ARB_SEL_CHECK_EN: when defined, ALU_Sel > SLT bypasses the ALU and flags resp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_sel,
  input  logic [DATA_W*NUM_REQ-1:0] req_op0,
  input  logic [DATA_W*NUM_REQ-1:0] req_op1,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  arb_state_e state, state_n;
  logic [GW-1:0] rr_ptr, grant, pick;
  logic [3:0] sel_q;
  logic [DATA_W-1:0] op0_q, op1_q, alu_y;
  logic bad, accept, hs;
  // Lowest offset from p wins: scan offsets high to low so the nearest valid overwrites last.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] p);
    int k;
    rr_pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NUM_REQ;
      if (v[k]) rr_pick = k[GW-1:0];
    end
  endfunction
  assign pick   = rr_pick(req_valid, rr_ptr);
  assign accept = state == IDLE && |req_valid;
  assign hs     = state == RESP && resp_ready[grant];
`ifdef ALU_ARB_SEL_CHECK_EN
  assign bad = sel_q > ALU_SLT;
`else
  assign bad = 1'b0;
`endif
  alu_share_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_sel(sel_q),
    .a      (op0_q),
    .b      (op1_q),
    .y      (alu_y)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n    = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        state_n   = accept ? EXEC : IDLE;
        req_ready = accept ? ONE << pick : '0;
      end
      EXEC: state_n = RESP;
      RESP: begin
        resp_valid = ONE << grant;
        state_n    = hs ? IDLE : RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant       <= '0;
      sel_q       <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        grant <= pick;
        sel_q <= req_sel[4*pick +: 4];
        op0_q <= req_op0[DATA_W*pick +: DATA_W];
        op1_q <= req_op1[DATA_W*pick +: DATA_W];
      end
      if (state == EXEC) begin
        resp_result <= bad ? '0 : alu_y;
        resp_err    <= bad;
      end
      if (hs) begin
        rr_ptr   <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        resp_err <= 1'b0;
      end
    end
  end
endmodule
